spi_burst_seq: RTL and testbench
================================

Name: spi_burst_seq

Overview:
- Parametrised SPI transaction sequencer; sits between system control and the SPI master core.
- Issues bursts of 1..MAX_BURST back-to-back transfers and drives start/spi_width/spi_cmd/index to the master.
- Advances on the master's out_flag (transfer-complete) pulse.
- Burst launch modes: periodic (programmable interval) or one-shot (trig pulse). Adds a programmable inter-transfer gap, per-burst latched config, a transfer watchdog, busy/done status and graceful stop.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency (documentation only; intervals are given in cycles)
- INTERVAL, 1_000_000, cycles between burst launches in periodic mode (>=2)
- MAX_BURST, 16, maximum transfers per burst (>=1)
- GAP_CYCLES, 4, idle cycles between transfers inside a burst (0 allowed)
- TIMEOUT, 4096, cycles allowed in XFER before the watchdog fires (>=2)
- WIDTH_W, 8, width of spi_width
- IDX_W, $clog2(MAX_BURST)+1, width of index and cfg_len

Ports:
- sys_clk in 1: single system clock, all logic on rising edge
- sys_rst in 1: synchronous, active-high reset
- enable in 1: sequencer enable; low = finish current transfer then go idle
- mode in 1: 0 = periodic, 1 = one-shot
- trig in 1: one-shot launch pulse (ignored in periodic mode or when busy)
- cfg_len in IDX_W: transfers per burst; 0 treated as 1; values >MAX_BURST clamped to MAX_BURST
- cfg_width in WIDTH_W: bits per transfer
- cfg_cmd in 2: SPI command/mode code
- out_flag in 1: transfer-complete pulse from the SPI master
- start out 1: one-cycle transfer request to the master
- spi_width out WIDTH_W: latched burst width
- spi_cmd out 2: latched burst command
- index out IDX_W: zero-based number of the current transfer within the burst
- busy out 1: high from burst launch until the DONE state exits
- burst_done out 1: one-cycle pulse at burst end
- err_timeout out 1: sticky watchdog flag; cleared at the next burst launch

Behaviour:
- Reset (sync, at sys_clk edge with sys_rst=1), regardless of state: state=IDLE, all counters=0, start=0, spi_width=0, spi_cmd=0, index=0, busy=0, burst_done=0, err_timeout=0. Reset mid-burst aborts immediately; a late out_flag after reset is ignored (only consumed in XFER).
- States: IDLE, WAIT, START, XFER, GAP, DONE. All outputs are registered.
- IDLE:
  - enable=1, mode=0 -> WAIT, interval counter cleared.
  - enable=1, mode=1, trig=1 -> launch.
- WAIT: interval counter increments each cycle; at INTERVAL-1 -> launch. enable=0 -> IDLE.
- Launch (in the same edge that enters START):
  - latch cfg_len (coerced), cfg_width and cfg_cmd into spi_width/spi_cmd/len_q;
  - index=0, busy=1, err_timeout=0.
  - Later cfg changes do not affect the running burst.
- START: lasts exactly one cycle, start=1, -> XFER. Latency: trig sampled at edge N -> start high during cycle N+1.
- XFER:
  - Watchdog counter increments each cycle.
  - out_flag=1 and index==len_q-1 -> DONE.
  - out_flag=1 otherwise -> index+1; then GAP if GAP_CYCLES>0, else START directly.
  - No out_flag by watchdog==TIMEOUT-1 -> err_timeout=1, -> DONE (burst aborted, index held).
  - If out_flag and the timeout occur in the same cycle, out_flag wins.
- GAP: counts GAP_CYCLES cycles, then -> START. enable=0 while in GAP -> DONE (graceful stop; an in-flight XFER always completes).
- DONE: burst_done=1 for one cycle, index->0.
  - Periodic mode with enable=1 -> WAIT (interval restarts at DONE, not at launch); otherwise -> IDLE.
  - busy drops on DONE exit.
- start is never high in two consecutive cycles. out_flag outside XFER is ignored.
- trig while busy is dropped, not queued.
- mode changes take effect only in IDLE/WAIT/DONE decisions.
- Counters are sized $clog2(max+1); no wrap is reachable in any state.

Decomposition:
- Shared package spi_seq_pkg:
  - state encoding localparams (IDLE..DONE);
  - SPI cmd codes (CMD_WRITE=0, CMD_READ=1, CMD_WR_RD=2, CMD_RSVD=3);
  - default WIDTH_W.
- One natural sub-module, spi_seq_timer: a loadable down-counter with a done flag. Instantiated three times (interval, gap, watchdog).
- The FSM and config latch stay in the top module.

Test Plan:
1. Periodic, INTERVAL=20, cfg_len=3, GAP_CYCLES=2; master returns out_flag 5 cycles after each start -> 3 start pulses, index 0,1,2, one burst_done, next launch 20 cycles after DONE.
2. One-shot with cfg_len=0, cfg_width=16, cfg_cmd=2 -> exactly one start, spi_width=16, spi_cmd=2; a trig while busy produces no extra start.
3. cfg_width changed mid-burst (8 to 12) -> spi_width stays 8 until the next launch.
4. TIMEOUT=10 with out_flag never returned -> err_timeout=1 at cycle 10 of XFER, burst_done pulse, index held, err_timeout cleared at the next launch.
5. enable dropped during GAP of a 4-transfer burst -> no further start, burst_done, then IDLE; enable dropped in XFER -> current transfer completes first.
6. sys_rst asserted in XFER with out_flag arriving the next cycle -> all outputs 0, state IDLE, the late out_flag ignored, no start.

Source files
------------

// File: rtl/spi_burst_seq_pkg.sv
// rtl/spi_burst_seq_pkg.sv - shared state encoding, command codes and helpers for the SPI burst sequencer
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_XFER  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] CMD_WRITE = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WR_RD = 2'd2;
  localparam logic [1:0] CMD_RSVD  = 2'd3;

  localparam int DEF_WIDTH_W = 8;

  // A zero length still runs one transfer; oversize requests saturate.
  function automatic int coerce_len(input int len, input int max_burst);
    if (len == 0) return 1;
    if (len > max_burst) return max_burst;
    return len;
  endfunction

endpackage

// File: rtl/spi_burst_seq_if.sv
// rtl/spi_burst_seq_if.sv - sequencer to SPI master core handshake bundle
interface spi_burst_seq_if #(
  parameter int WIDTH_W = 8,
  parameter int IDX_W   = 5
);
  logic               start;
  logic [WIDTH_W-1:0] spi_width;
  logic [1:0]         spi_cmd;
  logic [IDX_W-1:0]   index;
  logic               out_flag;

  modport master (output start, output spi_width, output spi_cmd, output index, input out_flag);
  modport slave  (input start, input spi_width, input spi_cmd, input index, output out_flag);
endinterface

// File: rtl/spi_burst_seq_timer.sv
// rtl/spi_burst_seq_timer.sv - loadable down-counter with a reached-zero flag
module spi_seq_timer #(
  parameter int MAX = 1,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/spi_burst_seq.sv
// rtl/spi_burst_seq.sv - burst sequencer driving start/width/cmd/index to an SPI master core
module spi_burst_seq
  import spi_seq_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INTERVAL   = 1_000_000,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096,
  parameter int WIDTH_W    = DEF_WIDTH_W,
  parameter int IDX_W      = $clog2(MAX_BURST) + 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic               mode,
  input  logic               trig,
  input  logic [IDX_W-1:0]   cfg_len,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [1:0]         cfg_cmd,
  spi_burst_seq_if.master    spi,
  output logic               busy,
  output logic               burst_done,
  output logic               err_timeout
);

  localparam int IV_W   = $clog2(INTERVAL + 1);
  localparam int GP_MAX = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int GP_W   = $clog2(GP_MAX + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  // Each timer is loaded with (cycles - 1) so done rises on the last cycle of the window.
  localparam logic [IV_W-1:0] IV_LOAD = IV_W'(INTERVAL - 1);
  localparam logic [GP_W-1:0] GP_LOAD = GP_W'(GP_MAX - 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               err_q, err_d;
  logic               start_q, busy_q, done_q;

  logic iv_load, gap_load, wd_load, launch;
  logic iv_done, gap_done, wd_done;

  spi_seq_timer #(.MAX(INTERVAL)) u_interval (
    .clk_i(sys_clk), .rst_i(sys_rst), .load_i(iv_load), .load_val_i(IV_LOAD),
    .en_i(state_q == ST_WAIT), .done_o(iv_done)
  );

  spi_seq_timer #(.MAX(GP_MAX)) u_gap (
    .clk_i(sys_clk), .rst_i(sys_rst), .load_i(gap_load), .load_val_i(GP_LOAD),
    .en_i(state_q == ST_GAP), .done_o(gap_done)
  );

  spi_seq_timer #(.MAX(TIMEOUT)) u_watchdog (
    .clk_i(sys_clk), .rst_i(sys_rst), .load_i(wd_load), .load_val_i(WD_LOAD),
    .en_i(state_q == ST_XFER), .done_o(wd_done)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    width_d  = width_q;
    cmd_d    = cmd_q;
    index_d  = index_q;
    err_d    = err_q;
    iv_load  = 1'b0;
    gap_load = 1'b0;
    wd_load  = 1'b0;
    launch   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (!mode) begin
            state_d = ST_WAIT;
            iv_load = 1'b1;
          end else if (trig) begin
            launch = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!enable || mode) begin
          state_d = ST_IDLE;
        end else if (iv_done) begin
          launch = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_XFER;
        wd_load = 1'b1;
      end
      ST_XFER: begin
        // A completion in the watchdog's final cycle still counts as success.
        if (spi.out_flag) begin
          if (index_q == len_q - 1'b1) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
            if (GAP_CYCLES == 0) begin
              state_d = enable ? ST_START : ST_DONE;
            end else begin
              state_d  = ST_GAP;
              gap_load = 1'b1;
            end
          end
        end else if (wd_done) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (!enable) begin
          state_d = ST_DONE;
        end else if (gap_done) begin
          state_d = ST_START;
        end
      end
      ST_DONE: begin
        index_d = '0;
        if (enable && !mode) begin
          state_d = ST_WAIT;
          iv_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d = ST_START;
      len_d   = IDX_W'(coerce_len(int'(cfg_len), MAX_BURST));
      width_d = cfg_width;
      cmd_d   = cfg_cmd;
      index_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      width_q <= '0;
      cmd_q   <= '0;
      index_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      width_q <= width_d;
      cmd_q   <= cmd_d;
      index_q <= index_d;
      err_q   <= err_d;
      start_q <= (state_d == ST_START);
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_WAIT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign spi.start     = start_q;
  assign spi.spi_width = width_q;
  assign spi.spi_cmd   = cmd_q;
  assign spi.index     = index_q;
  assign busy          = busy_q;
  assign burst_done    = done_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_spi_burst_seq.sv
// tb/tb_spi_burst_seq.sv - scoreboard bench for spi_burst_seq against a burst-level reference model
`timescale 1ns/1ps
module tb_spi_burst_seq;
  import spi_seq_pkg::*;

  localparam int INTERVAL   = 20;
  localparam int MAX_BURST  = 4;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 10;
  localparam int WIDTH_W    = 8;
  localparam int IDX_W      = $clog2(MAX_BURST) + 1;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [WIDTH_W-1:0] w;
    logic [1:0]         c;
  } st_exp_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
  } dn_exp_t;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               enable = 1'b0;
  logic               mode = 1'b0;
  logic               trig = 1'b0;
  logic [IDX_W-1:0]   cfg_len = '0;
  logic [WIDTH_W-1:0] cfg_width = '0;
  logic [1:0]         cfg_cmd = '0;
  logic               busy, burst_done, err_timeout;

  spi_burst_seq_if #(.WIDTH_W(WIDTH_W), .IDX_W(IDX_W)) sif ();

  spi_burst_seq #(
    .CLK_HZ(50_000_000), .INTERVAL(INTERVAL), .MAX_BURST(MAX_BURST),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .WIDTH_W(WIDTH_W), .IDX_W(IDX_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .mode(mode), .trig(trig),
    .cfg_len(cfg_len), .cfg_width(cfg_width), .cfg_cmd(cfg_cmd), .spi(sif),
    .busy(busy), .burst_done(burst_done), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  st_exp_t sq[$];
  dn_exp_t dq[$];
  int start_cyc[$];
  int done_cyc[$];
  int n_dones = 0;
  int fix_delay = 0;
  bit resp_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every start and burst_done the DUT presents is matched against the model queues.
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sif.start === 1'b1) begin
        chk("start_not_back_to_back", int'(prev_start), 0);
        if (sq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: got start at cycle %0d with index %0d, expected none", cyc, sif.index);
        end else begin
          st_exp_t e;
          e = sq.pop_front();
          chk("start_idx_width_cmd", int'({sif.index, sif.spi_width, sif.spi_cmd}), int'(e));
        end
        start_cyc.push_back(cyc);
      end
      if (burst_done === 1'b1) begin
        chk("busy_during_done", int'(busy), 1);
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got burst_done at cycle %0d, expected none", cyc);
        end else begin
          dn_exp_t e;
          e = dq.pop_front();
          chk("done_idx_err", int'({sif.index, err_timeout}), int'(e));
        end
        done_cyc.push_back(cyc);
        n_dones++;
      end
      prev_start = sif.start;
    end
  end

  // SPI master stand-in: completes each transfer d cycles after its start.
  initial begin
    sif.out_flag = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sif.start === 1'b1 && resp_en) begin
        int d;
        d = (fix_delay != 0) ? fix_delay : int'($urandom_range(1, 8));
        repeat (d) @(posedge sys_clk);
        #1 sif.out_flag = 1'b1;
        @(posedge sys_clk);
        #1 sif.out_flag = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish by cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_start(input int i, input int w, input int c);
    sq.push_back('{idx: IDX_W'(i), w: WIDTH_W'(w), c: 2'(c)});
  endtask

  task automatic push_done(input int i, input int err);
    dq.push_back('{idx: IDX_W'(i), err: 1'(err)});
  endtask

  // Model of a completed burst: transfer count from the length rules, one done at the last index.
  task automatic model_burst(input int len, input int w, input int c);
    int n;
    n = (len == 0) ? 1 : ((len > MAX_BURST) ? MAX_BURST : len);
    for (int i = 0; i < n; i++) push_start(i, w, c);
    push_done(n - 1, 0);
  endtask

  task automatic fire_trig(output int t);
    trig = 1'b1;
    t = cyc;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k;
    k = 0;
    while (n_dones < target && k < 600) begin
      @(posedge sys_clk);
      k++;
    end
    #1;
    chk(name, (n_dones >= target) ? 1 : 0, 1);
  endtask

  task automatic clear_log();
    start_cyc.delete();
    done_cyc.delete();
  endtask

  initial begin
    int t, t_en, base, len, w, c;

    repeat (3) tick();
    chk("rst_start", int'(sif.start), 0);
    chk("rst_width", int'(sif.spi_width), 0);
    chk("rst_cmd", int'(sif.spi_cmd), 0);
    chk("rst_index", int'(sif.index), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(burst_done), 0);
    chk("rst_err", int'(err_timeout), 0);
    sys_rst = 1'b0;
    tick();

    // Periodic bursts of 3 with a fixed master latency of 5 cycles.
    clear_log();
    mode = 1'b0; cfg_len = 3; cfg_width = 8'hA5; cfg_cmd = CMD_READ; fix_delay = 5;
    model_burst(3, 8'hA5, CMD_READ);
    model_burst(3, 8'hA5, CMD_READ);
    base = n_dones;
    enable = 1'b1;
    t_en = cyc;
    wait_done(base + 2, "t1_two_bursts");
    enable = 1'b0;
    chk("t1_first_launch", start_cyc[0], t_en + INTERVAL + 1);
    chk("t1_start_spacing", start_cyc[1] - start_cyc[0], 5 + GAP_CYCLES + 1);
    chk("t1_done_after_last", done_cyc[0] - start_cyc[2], 5 + 1);
    chk("t1_relaunch_from_done", start_cyc[3], done_cyc[0] + INTERVAL + 1);
    repeat (4) tick();
    chk("t1_idle_busy", int'(busy), 0);

    // One-shot, zero length, trig while busy must be dropped.
    clear_log();
    mode = 1'b1; enable = 1'b1; cfg_len = 0; cfg_width = 16; cfg_cmd = CMD_WR_RD; fix_delay = 6;
    model_burst(0, 16, CMD_WR_RD);
    base = n_dones;
    fire_trig(t);
    chk("t2_busy_at_start", int'(busy), 1);
    tick(); tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    wait_done(base + 1, "t2_done");
    chk("t2_trig_latency", start_cyc[0], t + 1);
    repeat (10) tick();
    chk("t2_single_start", start_cyc.size(), 1);

    // Config changed mid-burst is only picked up at the next launch.
    fix_delay = 0; cfg_len = 2; cfg_width = 8; cfg_cmd = CMD_WRITE;
    model_burst(2, 8, CMD_WRITE);
    base = n_dones;
    fire_trig(t);
    tick();
    cfg_width = 12;
    wait_done(base + 1, "t3_done_a");
    tick();
    model_burst(2, 12, CMD_WRITE);
    fire_trig(t);
    wait_done(base + 2, "t3_done_b");

    // Randomised one-shot bursts, including clamped and zero lengths.
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 3));
      cfg_len = IDX_W'(len); cfg_width = WIDTH_W'(w); cfg_cmd = 2'(c);
      model_burst(len, w, c);
      base = n_dones;
      tick();
      fire_trig(t);
      wait_done(base + 1, "rand_done");
    end

    // Watchdog on the second transfer: index held at 1, err sticky until next launch.
    clear_log();
    fix_delay = 3; cfg_len = 3; cfg_width = 8'h3C; cfg_cmd = CMD_RSVD;
    push_start(0, 8'h3C, CMD_RSVD);
    push_start(1, 8'h3C, CMD_RSVD);
    push_done(1, 1);
    base = n_dones;
    tick();
    fire_trig(t);
    repeat (5) tick();
    resp_en = 1'b0;
    wait_done(base + 1, "t4_done");
    chk("t4_timeout_cycle", done_cyc[0] - start_cyc[1], TIMEOUT + 1);
    repeat (3) tick();
    chk("t4_err_sticky", int'(err_timeout), 1);
    chk("t4_index_cleared", int'(sif.index), 0);
    resp_en = 1'b1;
    cfg_len = 1;
    model_burst(1, 8'h3C, CMD_RSVD);
    fire_trig(t);
    chk("t4_err_cleared_on_launch", int'(err_timeout), 0);
    wait_done(base + 2, "t4_done_b");

    // Enable dropped in GAP: no further start, done at index 1.
    clear_log();
    fix_delay = 3; cfg_len = 4; cfg_width = 8'h55; cfg_cmd = CMD_WRITE;
    push_start(0, 8'h55, CMD_WRITE);
    push_done(1, 0);
    base = n_dones;
    tick();
    fire_trig(t);
    repeat (4) tick();
    enable = 1'b0;
    wait_done(base + 1, "t5_gap_done");
    chk("t5_gap_done_cycle", done_cyc[0], t + 6);
    repeat (6) tick();
    chk("t5_gap_idle_busy", int'(busy), 0);
    chk("t5_gap_one_start", start_cyc.size(), 1);
    enable = 1'b1;

    // Enable dropped in XFER: the running transfer completes first.
    clear_log();
    fix_delay = 4; cfg_len = 3;
    push_start(0, 8'h55, CMD_WRITE);
    push_done(1, 0);
    base = n_dones;
    tick();
    fire_trig(t);
    tick();
    enable = 1'b0;
    wait_done(base + 1, "t5_xfer_done");
    chk("t5_xfer_done_cycle", done_cyc[0], t + 7);
    repeat (6) tick();
    chk("t5_xfer_one_start", start_cyc.size(), 1);
    enable = 1'b1;

    // Reset in XFER, late out_flag afterwards must be ignored.
    clear_log();
    resp_en = 1'b0; cfg_len = 2; cfg_width = 8'h99; cfg_cmd = CMD_READ;
    push_start(0, 8'h99, CMD_READ);
    tick();
    fire_trig(t);
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    sif.out_flag = 1'b1;
    chk("t6_start", int'(sif.start), 0);
    chk("t6_width", int'(sif.spi_width), 0);
    chk("t6_cmd", int'(sif.spi_cmd), 0);
    chk("t6_index", int'(sif.index), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(burst_done), 0);
    chk("t6_err", int'(err_timeout), 0);
    tick();
    sif.out_flag = 1'b0;
    repeat (8) tick();
    chk("t6_no_start_after_rst", start_cyc.size(), 1);
    chk("t6_no_done_after_rst", done_cyc.size(), 0);
    chk("t6_idle_busy", int'(busy), 0);

    chk("sb_starts_drained", sq.size(), 0);
    chk("sb_dones_drained", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
